bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Owns the system bus and shares it between the s1c88 CPU (default owner) and NUM_MASTERS secondary bus masters.
- Secondary master 0 is the PRC; higher indices are reserved for future DMA engines.
- Sequences the CPU bus_request/bus_ack handshake, grants one secondary master at a time in round-robin order, and drives the muxed bus seen by memory and the register decoders.

Parameters:
- NUM_MASTERS, 2, number of secondary masters (1..4).
- MAX_HOLD, 4096, ownership cycles before the hold-timeout flag fires (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_MASTERS  per-master bus request; level, held until done.
- gnt  out  NUM_MASTERS  one-hot grant (bus_ack to each master).
- cpu_bus_request  out  1  request to the CPU to release the bus.
- cpu_bus_ack  in  1  CPU has released the bus.
- cpu_address, cpu_data_out, cpu_read, cpu_write, cpu_bus_status  in  24/8/1/1/2  CPU bus outputs.
- m_address, m_data_out, m_read, m_write, m_bus_status  in  packed 24/8/1/1/2 x NUM_MASTERS  master bus outputs.
- address_out, data_out, read, write, bus_status  out  24/8/1/1/2  muxed system bus.
- owner  out  3  0 = CPU, k+1 = master k.
- timeout_irq  out  1  one-cycle pulse on hold timeout.

Behaviour:
- Reset (async): state = IDLE; gnt = 0; cpu_bus_request = 0; owner = 0; rr_ptr = 0; timeout_irq = 0. Muxed bus selects CPU.
- IDLE: the CPU owns the bus. If any req is high, cpu_bus_request is set high on the next edge and the state goes to WAIT_ACK.
- WAIT_ACK: cpu_bus_request is held high. On the first edge with cpu_bus_ack = 1, the arbiter picks winner k and registers gnt[k] = 1, owner = k+1, state = GRANT.
  - Latency from req rising to gnt rising = 2 cycles + CPU ack delay.
  - If every req drops before the ack arrives, cpu_bus_request falls and the state goes to RELEASE.
- Winner selection: round-robin. Scan starts at rr_ptr and takes the first asserted req. rr_ptr = k+1 (mod NUM_MASTERS) is latched at grant.
- GRANT: gnt[k] stays high while req[k] = 1; requests from other masters are ignored.
  - On the edge where req[k] = 0: gnt goes to 0 and owner goes to 0.
  - If another req is high, the state goes to TURN: one dead cycle with no grant, read = write = 0, cpu_bus_request held high. Selection then repeats and the next winner is granted on the following edge without re-handshaking the CPU.
  - Otherwise cpu_bus_request falls and the state goes to RELEASE.
- RELEASE: wait for cpu_bus_ack = 0, then go to IDLE. A new req arriving during RELEASE is held pending until IDLE.
- Bus mux (combinational from registered owner):
  - owner 0 passes the CPU signals through.
  - owner k+1 passes master k's signals through.
  - In TURN and WAIT_ACK the mux passes the CPU signals, but read and write are forced to 0 while cpu_bus_ack = 1.
- Invariants: gnt is never nonzero unless cpu_bus_ack = 1; at most one gnt bit is high.
- Protocol violation: cpu_bus_ack falling while in GRANT. The grant is revoked on the next edge and the state goes to IDLE with cpu_bus_request = 0.
- Simultaneous events: a req rising on the same edge as a release is treated as pending; it is evaluated in the TURN/RELEASE path, never granted the same cycle.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A 13-bit hold counter clears on every grant and increments each GRANT cycle, saturating.
  - When it reaches MAX_HOLD, timeout_irq pulses for exactly one cycle.
  - The grant is not revoked.
- Undefined: no counter is built and timeout_irq is tied to 0.

Test Plan:
- Single request: req[0] = 1 at cycle 10, cpu_bus_ack = 1 at cycle 13 -> cpu_bus_request = 1 at cycle 11, gnt = 2'b01 at cycle 14, address_out = m_address[0]. Drop req[0] at cycle 20 -> gnt = 0 at cycle 21, cpu_bus_request = 0 at cycle 21, IDLE after ack falls.
- Round-robin: req = 2'b11 held, each master drops its req 5 cycles after its grant -> order master 0, TURN, master 1, TURN, master 0. Exactly one dead cycle between grants; cpu_bus_request stays high throughout.
- Abort: req[1] pulses high for 1 cycle, CPU never acks -> cpu_bus_request rises then falls, gnt never asserts, state returns to IDLE.
- Reset mid-grant: assert reset during GRANT -> gnt, cpu_bus_request and owner are 0 immediately (asynchronously); bus mux shows CPU signals.
- Ack violation: drop cpu_bus_ack during GRANT -> gnt = 0 on the next edge, state IDLE.
- Timeout (BUS_ARBITER_TIMEOUT_EN defined, MAX_HOLD = 16): hold req[0] for 40 cycles -> timeout_irq high for exactly one cycle, 16 cycles after the grant; gnt stays 1. With the macro undefined, timeout_irq stays 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the system bus between the s1c88 CPU (default owner)
// and NUM_MASTERS secondary masters (master 0 = PRC, others = future DMA).
// Handles the CPU bus_request/bus_ack handshake and grants one secondary
// master at a time in round-robin order. It also drives the muxed system bus.
// Optional hold-timeout flag: define BUS_ARBITER_TIMEOUT_EN to build it.
module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD    = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    req,
  output logic [NUM_MASTERS-1:0]    gnt,
  output logic                      cpu_bus_request,
  input  logic                      cpu_bus_ack,
  input  logic [23:0]               cpu_address,
  input  logic [7:0]                cpu_data_out,
  input  logic                      cpu_read,
  input  logic                      cpu_write,
  input  logic [1:0]                cpu_bus_status,
  input  logic [24*NUM_MASTERS-1:0] m_address,
  input  logic [8*NUM_MASTERS-1:0]  m_data_out,
  input  logic [NUM_MASTERS-1:0]    m_read,
  input  logic [NUM_MASTERS-1:0]    m_write,
  input  logic [2*NUM_MASTERS-1:0]  m_bus_status,
  output logic [23:0]               address_out,
  output logic [7:0]                data_out,
  output logic                      read,
  output logic                      write,
  output logic [1:0]                bus_status,
  output logic [2:0]                owner,
  output logic                      timeout_irq
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_GRANT,
    S_TURN,
    S_RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic                   cbr_q, cbr_d;
  logic [2:0]             owner_q, owner_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          cur_q, cur_d;
  logic                   grant_now;

  // Per-master views of the packed master buses.
  logic [23:0] m_addr_arr   [NUM_MASTERS];
  logic [7:0]  m_data_arr   [NUM_MASTERS];
  logic [1:0]  m_status_arr [NUM_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign m_addr_arr[gi]   = m_address[gi*24 +: 24];
      assign m_data_arr[gi]   = m_data_out[gi*8 +: 8];
      assign m_status_arr[gi] = m_bus_status[gi*2 +: 2];
    end
  endgenerate

  // Round-robin winner: lowest requester at or above rr_ptr, else lowest overall.
  logic [NUM_MASTERS-1:0] req_hi;
  logic [PW-1:0]          win_hi, win_any, win, win_next;
  logic                   any_req;
  logic [NUM_MASTERS-1:0] win_onehot;
  logic [2:0]             win_owner;

  // Combinational winner search over the request vector.
  always_comb begin
    req_hi  = '0;
    win_hi  = '0;
    win_any = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      req_hi[j] = req[j] && (j >= int'(rr_ptr_q));
    end
    for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
      if (req_hi[j]) win_hi = PW'(j);
      if (req[j])    win_any = PW'(j);
    end
  end

  assign any_req    = |req;
  assign win        = (|req_hi) ? win_hi : win_any;
  assign win_next   = (int'(win) == NUM_MASTERS - 1) ? '0 : win + PW'(1);
  assign win_onehot = NUM_MASTERS'(1) << win;
  assign win_owner  = 3'(win) + 3'd1;

  // Arbiter state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      cbr_q    <= 1'b0;
      owner_q  <= 3'd0;
      rr_ptr_q <= '0;
      cur_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cbr_q    <= cbr_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cur_q    <= cur_d;
    end
  end

  // Next-state logic: CPU handshake, grant, turnaround and release.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cbr_d     = cbr_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    cur_d     = cur_q;
    grant_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d   = '0;
        owner_d = 3'd0;
        cbr_d   = 1'b0;
        if (any_req) begin
          cbr_d   = 1'b1;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK, S_TURN: begin
        cbr_d = 1'b1;
        if (state_q == S_TURN && !cpu_bus_ack) begin
          // CPU took the bus back mid-turnaround: abandon the sequence.
          cbr_d   = 1'b0;
          state_d = S_IDLE;
        end else if (!any_req) begin
          cbr_d   = 1'b0;
          state_d = S_RELEASE;
        end else if (cpu_bus_ack) begin
          gnt_d     = win_onehot;
          owner_d   = win_owner;
          rr_ptr_d  = win_next;
          cur_d     = win;
          grant_now = 1'b1;
          state_d   = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!cpu_bus_ack) begin
          // CPU dropped ack while a master owns the bus: revoke everything.
          gnt_d   = '0;
          owner_d = 3'd0;
          cbr_d   = 1'b0;
          state_d = S_IDLE;
        end else if (!req[cur_q]) begin
          gnt_d   = '0;
          owner_d = 3'd0;
          if (any_req) begin
            state_d = S_TURN;
          end else begin
            cbr_d   = 1'b0;
            state_d = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        cbr_d = 1'b0;
        if (!cpu_bus_ack) state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        owner_d = 3'd0;
        cbr_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus mux driven from the registered owner; turnaround/handshake blank strobes.
  always_comb begin
    address_out = cpu_address;
    data_out    = cpu_data_out;
    read        = cpu_read;
    write       = cpu_write;
    bus_status  = cpu_bus_status;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (owner_q == 3'(k + 1)) begin
        address_out = m_addr_arr[k];
        data_out    = m_data_arr[k];
        read        = m_read[k];
        write       = m_write[k];
        bus_status  = m_status_arr[k];
      end
    end
    if ((state_q == S_TURN || state_q == S_WAIT_ACK) && cpu_bus_ack) begin
      read  = 1'b0;
      write = 1'b0;
    end
  end

  assign gnt             = gnt_q;
  assign cpu_bus_request = cbr_q;
  assign owner           = owner_q;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [12:0] HOLD_LIMIT = 13'(MAX_HOLD);

  logic [12:0] hold_q, hold_d;
  logic        irq_q, irq_d;

  // Hold counter: cleared on each grant, counts GRANT cycles, saturates.
  always_comb begin
    hold_d = hold_q;
    irq_d  = 1'b0;
    if (grant_now) begin
      hold_d = '0;
    end else if (state_q == S_GRANT && hold_q != 13'h1FFF) begin
      hold_d = hold_q + 13'd1;
      irq_d  = (hold_d == HOLD_LIMIT);
    end
  end

  // Hold counter and single-cycle timeout pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      irq_q  <= irq_d;
    end
  end

  assign timeout_irq = irq_q;
`else
  localparam int unused_max_hold = MAX_HOLD;
  logic unused_grant_now;
  assign unused_grant_now = grant_now;
  assign timeout_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (NUM_MASTERS = 2, MAX_HOLD = 16).
module tb_bus_arbiter;
  localparam int N = 2;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          cpu_bus_request;
  logic          cpu_bus_ack;
  logic [23:0]   cpu_address;
  logic [7:0]    cpu_data_out;
  logic          cpu_read, cpu_write;
  logic [1:0]    cpu_bus_status;
  logic [24*N-1:0] m_address;
  logic [8*N-1:0]  m_data_out;
  logic [N-1:0]    m_read, m_write;
  logic [2*N-1:0]  m_bus_status;
  logic [23:0]   address_out;
  logic [7:0]    data_out;
  logic          read, write;
  logic [1:0]    bus_status;
  logic [2:0]    owner;
  logic          timeout_irq;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(16)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .cpu_bus_request(cpu_bus_request), .cpu_bus_ack(cpu_bus_ack),
    .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_bus_status(cpu_bus_status),
    .m_address(m_address), .m_data_out(m_data_out), .m_read(m_read),
    .m_write(m_write), .m_bus_status(m_bus_status),
    .address_out(address_out), .data_out(data_out), .read(read),
    .write(write), .bus_status(bus_status), .owner(owner),
    .timeout_irq(timeout_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; cpu_bus_ack = 1'b0;
    cpu_address = 24'hC0C0C0; cpu_data_out = 8'hCC;
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_bus_status = 2'b11;
    m_address = {24'hB1B1B1, 24'hA0A0A0};
    m_data_out = {8'hB1, 8'hA0};
    m_read = 2'b01; m_write = 2'b10; m_bus_status = {2'b10, 2'b01};

    // Reset state
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_cbr", 32'(cpu_bus_request), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_addr", 32'(address_out), 32'hC0C0C0);
    check("rst_irq", 32'(timeout_irq), 32'h0);
    reset = 1'b0;
    tick();
    check("idle_read", 32'(read), 32'h1);
    $display("txn reset: done");

    // Single request from master 0
    req = 2'b01;
    check("s_cbr_pre", 32'(cpu_bus_request), 32'h0);
    tick();
    check("s_cbr", 32'(cpu_bus_request), 32'h1);
    check("s_gnt_wait", 32'(gnt), 32'h0);
    tick(); tick();
    check("s_wait_read_noack", 32'(read), 32'h1);
    cpu_bus_ack = 1'b1;
    #1;
    check("s_wait_read_forced", 32'(read), 32'h0);
    check("s_wait_write_forced", 32'(write), 32'h0);
    check("s_wait_addr", 32'(address_out), 32'hC0C0C0);
    tick();
    check("s_gnt", 32'(gnt), 32'h1);
    check("s_owner", 32'(owner), 32'h1);
    check("s_addr", 32'(address_out), 32'hA0A0A0);
    check("s_data", 32'(data_out), 32'hA0);
    check("s_read", 32'(read), 32'h1);
    check("s_write", 32'(write), 32'h0);
    check("s_status", 32'(bus_status), 32'h1);
    repeat (5) tick();
    check("s_gnt_hold", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    check("s_rel_gnt", 32'(gnt), 32'h0);
    check("s_rel_cbr", 32'(cpu_bus_request), 32'h0);
    check("s_rel_owner", 32'(owner), 32'h0);
    check("s_rel_addr", 32'(address_out), 32'hC0C0C0);
    req = 2'b01;
    tick();
    check("s_pending_cbr", 32'(cpu_bus_request), 32'h0);
    cpu_bus_ack = 1'b0;
    tick();
    check("s_idle_cbr", 32'(cpu_bus_request), 32'h0);
    tick();
    check("s_pending_taken", 32'(cpu_bus_request), 32'h1);
    req = 2'b00;
    tick();
    check("s_drop_cbr", 32'(cpu_bus_request), 32'h0);
    tick();
    $display("txn single: done");

    // Abort: one-cycle request, CPU never acks
    req = 2'b10;
    tick();
    req = 2'b00;
    check("a_cbr_up", 32'(cpu_bus_request), 32'h1);
    tick();
    check("a_cbr_down", 32'(cpu_bus_request), 32'h0);
    check("a_gnt", 32'(gnt), 32'h0);
    tick(); tick();
    check("a_idle_cbr", 32'(cpu_bus_request), 32'h0);
    check("a_idle_gnt", 32'(gnt), 32'h0);
    $display("txn abort: done");

    // Round-robin from a fresh pointer
    reset = 1'b1; tick(); reset = 1'b0; tick();
    req = 2'b11;
    tick();
    check("rr_cbr", 32'(cpu_bus_request), 32'h1);
    cpu_bus_ack = 1'b1;
    tick();
    check("rr_g0", 32'(gnt), 32'h1);
    check("rr_g0_owner", 32'(owner), 32'h1);
    repeat (5) tick();
    req = 2'b10;
    tick();
    check("rr_turn1_gnt", 32'(gnt), 32'h0);
    check("rr_turn1_owner", 32'(owner), 32'h0);
    check("rr_turn1_cbr", 32'(cpu_bus_request), 32'h1);
    check("rr_turn1_read", 32'(read), 32'h0);
    check("rr_turn1_write", 32'(write), 32'h0);
    req = 2'b11;
    tick();
    check("rr_g1", 32'(gnt), 32'h2);
    check("rr_g1_owner", 32'(owner), 32'h2);
    check("rr_g1_addr", 32'(address_out), 32'hB1B1B1);
    check("rr_g1_data", 32'(data_out), 32'hB1);
    check("rr_g1_write", 32'(write), 32'h1);
    check("rr_g1_status", 32'(bus_status), 32'h2);
    repeat (5) tick();
    req = 2'b01;
    tick();
    check("rr_turn2_gnt", 32'(gnt), 32'h0);
    check("rr_turn2_cbr", 32'(cpu_bus_request), 32'h1);
    tick();
    check("rr_g0b", 32'(gnt), 32'h1);
    check("rr_g0b_owner", 32'(owner), 32'h1);
    $display("txn round_robin: done");

    // Ack violation during grant
    cpu_bus_ack = 1'b0;
    tick();
    check("v_gnt", 32'(gnt), 32'h0);
    check("v_owner", 32'(owner), 32'h0);
    check("v_cbr", 32'(cpu_bus_request), 32'h0);
    tick();
    check("v_idle_rereq", 32'(cpu_bus_request), 32'h1);
    check("v_idle_gnt", 32'(gnt), 32'h0);
    $display("txn ack_violation: done");

    // Asynchronous reset during grant
    cpu_bus_ack = 1'b1;
    tick();
    check("r_gnt_before", 32'(gnt), 32'h1);
    reset = 1'b1;
    #1;
    check("r_gnt", 32'(gnt), 32'h0);
    check("r_cbr", 32'(cpu_bus_request), 32'h0);
    check("r_owner", 32'(owner), 32'h0);
    check("r_addr", 32'(address_out), 32'hC0C0C0);
    req = 2'b00; cpu_bus_ack = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    $display("txn reset_mid_grant: done");

    // Hold timeout
    req = 2'b01;
    tick();
    cpu_bus_ack = 1'b1;
    tick();
    check("t_gnt", 32'(gnt), 32'h1);
    check("t_irq0", 32'(timeout_irq), 32'h0);
    for (int i = 1; i < 40; i++) begin
      tick();
      check($sformatf("t_irq_%0d", i), 32'(timeout_irq), 32'(TO_EN && (i == 16)));
      check($sformatf("t_gnt_%0d", i), 32'(gnt), 32'h1);
    end
    req = 2'b00;
    tick();
    check("t_rel_cbr", 32'(cpu_bus_request), 32'h0);
    cpu_bus_ack = 1'b0;
    tick();
    $display("txn timeout: done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
